wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 16 x 16-bit, two combinational read ports with
// write-through bypass, WB-to-EX forward tap, sticky halt and a saturating commit counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_hlt,
  input  logic        wb_from_mem,
  input  logic        wb_WriteReg,
  input  logic [3:0]  wb_DstReg,
  input  logic [15:0] wb_MemData,
  input  logic [15:0] wb_DstData,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic        fwd_valid,
  output logic [3:0]  fwd_reg,
  output logic [15:0] fwd_data,
  output logic        halted,
  output logic [15:0] wr_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] regs [16];
  logic [15:0] wb_val;
  logic        commit;

  // A write commits only when requested, not halting now or already halted,
  // and not aimed at r0; the same qualifier gates bypass, forward and count.
  assign wb_val = wb_from_mem ? wb_MemData : wb_DstData;
  assign commit = wb_WriteReg & ~wb_hlt & ~halted & (wb_DstReg != 4'd0);

  assign fwd_valid = commit;
  assign fwd_reg   = wb_DstReg;
  assign fwd_data  = wb_val;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (wb_hlt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'd0;
      end
    end else if (commit) begin
      regs[wb_DstReg] <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= 16'd0;
    end else if (commit && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // r0 is never written, so an unbypassed read of index 0 is always zero.
  always_comb begin
    SrcData1 = regs[SrcReg1];
    if (commit && (SrcReg1 == wb_DstReg)) SrcData1 = wb_val;
  end

  always_comb begin
    SrcData2 = regs[SrcReg2];
    if (commit && (SrcReg2 == wb_DstReg)) SrcData2 = wb_val;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write/read, mux + bypass, r0, halt,
// asynchronous reset and counter saturation.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_hlt;
  logic        wb_from_mem;
  logic        wb_WriteReg;
  logic [3:0]  wb_DstReg;
  logic [15:0] wb_MemData;
  logic [15:0] wb_DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        fwd_valid;
  logic [3:0]  fwd_reg;
  logic [15:0] fwd_data;
  logic        halted;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  idx_q[$];

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .wb_hlt      (wb_hlt),
    .wb_from_mem (wb_from_mem),
    .wb_WriteReg (wb_WriteReg),
    .wb_DstReg   (wb_DstReg),
    .wb_MemData  (wb_MemData),
    .wb_DstData  (wb_DstData),
    .SrcReg1     (SrcReg1),
    .SrcReg2     (SrcReg2),
    .SrcData1    (SrcData1),
    .SrcData2    (SrcData2),
    .fwd_valid   (fwd_valid),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .halted      (halted),
    .wr_count    (wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wb_hlt      = 1'b0;
    wb_from_mem = 1'b0;
    wb_WriteReg = 1'b0;
    wb_DstReg   = 4'd0;
    wb_MemData  = 16'd0;
    wb_DstData  = 16'd0;
    SrcReg1     = 4'd0;
    SrcReg2     = 4'd0;
  endtask

  task automatic drive_write(input logic [3:0] idx, input logic [15:0] val);
    wb_WriteReg = 1'b1;
    wb_from_mem = 1'b0;
    wb_DstReg   = idx;
    wb_DstData  = val;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [15:0] val);
    drive_write(idx, val);
    tick();
    wb_WriteReg = 1'b0;
    settle();
  endtask

  task automatic read1(input logic [3:0] idx);
    SrcReg1 = idx;
    settle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #12;
    check("reset_halted", {15'd0, halted}, 16'd0);
    check("reset_count", wr_count, 16'd0);
    read1(4'd5);
    check("reset_read5", SrcData1, 16'd0);
    #10;
    rst = 1'b1;
    tick();

    // write/read
    drive_write(4'd5, 16'h1234);
    settle();
    check("wr_fwd_valid", {15'd0, fwd_valid}, 16'd1);
    check("wr_fwd_reg", {12'd0, fwd_reg}, 16'd5);
    check("wr_fwd_data", fwd_data, 16'h1234);
    tick();
    wb_WriteReg = 1'b0;
    read1(4'd5);
    check("wr_read5", SrcData1, 16'h1234);
    check("wr_count1", wr_count, 16'd1);

    // mux select + dual bypass, with port 2 also checked off-target
    wb_WriteReg = 1'b1;
    wb_from_mem = 1'b1;
    wb_MemData  = 16'hBEEF;
    wb_DstData  = 16'h5555;
    wb_DstReg   = 4'd3;
    SrcReg1     = 4'd3;
    SrcReg2     = 4'd3;
    settle();
    check("byp_src1", SrcData1, 16'hBEEF);
    check("byp_src2", SrcData2, 16'hBEEF);
    check("byp_fwd_valid", {15'd0, fwd_valid}, 16'd1);
    check("byp_fwd_reg", {12'd0, fwd_reg}, 16'd3);
    check("byp_fwd_data", fwd_data, 16'hBEEF);
    SrcReg2 = 4'd5;
    settle();
    check("byp_other_port", SrcData2, 16'h1234);
    wb_from_mem = 1'b0;
    settle();
    check("mux_dst_sel", fwd_data, 16'h5555);
    wb_from_mem = 1'b1;
    tick();
    wb_WriteReg = 1'b0;
    settle();
    check("byp_stored3", SrcData1, 16'hBEEF);
    check("byp_count2", wr_count, 16'd2);

    // r0 write is dropped
    drive_write(4'd0, 16'hFFFF);
    SrcReg1 = 4'd0;
    settle();
    check("r0_bypass", SrcData1, 16'd0);
    check("r0_fwd_valid", {15'd0, fwd_valid}, 16'd0);
    tick();
    wb_WriteReg = 1'b0;
    settle();
    check("r0_read", SrcData1, 16'd0);
    check("r0_count", wr_count, 16'd2);

    // halt suppresses the coincident write and freezes everything after
    do_write(4'd7, 16'h0011);
    check("pre_halt_count", wr_count, 16'd3);
    drive_write(4'd7, 16'h00AA);
    wb_hlt  = 1'b1;
    SrcReg1 = 4'd7;
    settle();
    check("halt_fwd_valid", {15'd0, fwd_valid}, 16'd0);
    check("halt_no_bypass", SrcData1, 16'h0011);
    check("halt_not_yet", {15'd0, halted}, 16'd0);
    tick();
    wb_hlt = 1'b0;
    settle();
    check("halt_set", {15'd0, halted}, 16'd1);
    check("halt_reg7", SrcData1, 16'h0011);
    check("halt_count", wr_count, 16'd3);
    drive_write(4'd8, 16'h7777);
    SrcReg1 = 4'd8;
    SrcReg2 = 4'd3;
    settle();
    check("halted_fwd_valid", {15'd0, fwd_valid}, 16'd0);
    check("halted_no_bypass", SrcData1, 16'd0);
    check("halted_read3", SrcData2, 16'hBEEF);
    tick();
    wb_WriteReg = 1'b0;
    settle();
    check("halted_reg8", SrcData1, 16'd0);
    check("halted_count", wr_count, 16'd3);
    check("halted_sticky", {15'd0, halted}, 16'd1);

    // async reset between edges
    #2;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
    check("rst_clear_halt", {15'd0, halted}, 16'd0);
    idx_q = '{4'd1, 4'd2, 4'd4, 4'd9};
    exp_q = '{16'h1111, 16'h2222, 16'h4444, 16'h9999};
    foreach (idx_q[i]) do_write(idx_q[i], exp_q[i]);
    check("four_writes_count", wr_count, 16'd4);
    wb_hlt = 1'b1;
    tick();
    wb_hlt = 1'b0;
    settle();
    check("four_writes_halted", {15'd0, halted}, 16'd1);
    read1(4'd9);
    check("pre_rst_reg9", SrcData1, 16'h9999);
    #2;
    rst = 1'b0;
    #1;
    check("async_halted", {15'd0, halted}, 16'd0);
    check("async_count", wr_count, 16'd0);
    while (idx_q.size() > 0) begin
      read1(idx_q.pop_front());
      void'(exp_q.pop_front());
      check("async_reg_clear", SrcData1, 16'd0);
    end

    // a commit across an edge held in reset is discarded
    drive_write(4'd1, 16'hCAFE);
    SrcReg1 = 4'd6;
    settle();
    check("rst_fwd_valid", {15'd0, fwd_valid}, 16'd1);
    SrcReg1 = 4'd1;
    settle();
    check("rst_bypass", SrcData1, 16'hCAFE);
    tick();
    wb_WriteReg = 1'b0;
    settle();
    check("rst_edge_reg1", SrcData1, 16'd0);
    check("rst_edge_count", wr_count, 16'd0);
    #2;
    rst = 1'b1;
    drive_write(4'd2, 16'hABCD);
    SrcReg1 = 4'd2;
    tick();
    wb_WriteReg = 1'b0;
    settle();
    check("first_write", SrcData1, 16'hABCD);
    check("first_count", wr_count, 16'd1);

    // saturation: from 1, 65534 commits reach FFFF, one more must hold
    drive_write(4'd1, 16'h0001);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_reach", wr_count, 16'hFFFF);
    tick();
    check("sat_hold", wr_count, 16'hFFFF);
    wb_WriteReg = 1'b0;
    read1(4'd1);
    check("sat_reg1", SrcData1, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
